// File: rtl/spi_slave_regs_if.sv
// SPI pins plus register-file observation/write-strobe bus for spi_slave_regs.
// master drives the SPI pins, slave drives everything the block reports back.
interface spi_slave_regs_if #(
  parameter int ADDR_W = 4
);
  logic                        cs_n;
  logic                        sclk;
  logic                        mosi;
  logic                        miso;
  logic                        miso_oe;
  logic [8*(2**ADDR_W)-1:0]    reg_bus;
  logic                        wr_valid;
  logic [ADDR_W-1:0]           wr_addr;
  logic [7:0]                  wr_data;
  logic                        frame_err;

  modport master (
    output cs_n, sclk, mosi,
    input  miso, miso_oe, reg_bus, wr_valid, wr_addr, wr_data, frame_err
  );

  modport slave (
    input  cs_n, sclk, mosi,
    output miso, miso_oe, reg_bus, wr_valid, wr_addr, wr_data, frame_err
  );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with a 2**ADDR_W x 8 register file, oversampled on clk.
// Define SPI_SLAVE_AUTOINC_EN to advance the address after every data byte.
module spi_slave_regs #(
  parameter int         ADDR_W  = 4,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_regs_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t              state_q;
  logic                cs_meta_q, cs_sync_q, cs_dly_q;
  logic                sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic                mosi_meta_q, mosi_sync_q;
  logic [1:0]          live_q;
  logic                armed_q;
  logic [2:0]          bitcnt_q;
  logic [6:0]          shin_q;
  logic                rd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          shout_q;
  logic                oe_q;
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          wr_data_q;
  logic                frame_err_q;
  logic [7:0]          regs_q [NREG];

  logic                sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0]          rx_byte;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_SLAVE_AUTOINC_EN
    return a + ADDR_W'(1);
`else
    return a;
`endif
  endfunction

  // Synchronisers idle at cs_n=1, sclk=0; live_q tracks when the chain holds real pin values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_dly_q    <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_dly_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      live_q      <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      cs_meta_q   <= bus.cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_dly_q    <= cs_sync_q;
      sclk_meta_q <= bus.sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_dly_q  <= sclk_sync_q;
      mosi_meta_q <= bus.mosi;
      mosi_sync_q <= mosi_meta_q;
      live_q      <= {live_q[0], 1'b1};
      // A cs_n held low through reset must go high before a frame is accepted.
      armed_q     <= armed_q | (live_q[1] & cs_sync_q);
    end
  end

  always_comb begin
    sclk_rise = sclk_sync_q & ~sclk_dly_q;
    sclk_fall = ~sclk_sync_q & sclk_dly_q;
    cs_fall   = armed_q & ~cs_sync_q & cs_dly_q;
    cs_rise   = cs_sync_q & ~cs_dly_q;
    rx_byte   = {shin_q, mosi_sync_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      shin_q      <= 7'd0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      shout_q     <= 8'h00;
      oe_q        <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= RST_VAL;
    end else begin
      wr_valid_q <= 1'b0;
      if (cs_rise) begin
        if (state_q != IDLE && bitcnt_q != 3'd0) frame_err_q <= 1'b1;
        state_q  <= IDLE;
        bitcnt_q <= 3'd0;
        oe_q     <= 1'b0;
        shout_q  <= 8'h00;
      end else if (cs_fall) begin
        state_q     <= CMD;
        bitcnt_q    <= 3'd0;
        oe_q        <= 1'b1;
        frame_err_q <= 1'b0;
        shout_q     <= 8'h00;
      end else if (state_q != IDLE) begin
        if (sclk_rise) begin
          bitcnt_q <= bitcnt_q + 3'd1;
          shin_q   <= rx_byte[6:0];
          if (bitcnt_q == 3'd7) begin
            if (state_q == CMD) begin
              state_q <= DATA;
              rd_q    <= rx_byte[7];
              addr_q  <= rx_byte[ADDR_W-1:0];
              if (rx_byte[7]) shout_q <= regs_q[rx_byte[ADDR_W-1:0]];
            end else if (rd_q) begin
              addr_q  <= next_addr(addr_q);
              shout_q <= regs_q[next_addr(addr_q)];
            end else begin
              regs_q[addr_q] <= rx_byte;
              wr_valid_q     <= 1'b1;
              wr_addr_q      <= addr_q;
              wr_data_q      <= rx_byte;
              addr_q         <= next_addr(addr_q);
            end
          end
        end else if (sclk_fall && state_q == DATA && rd_q && bitcnt_q != 3'd0) begin
          // The fall right after a byte boundary keeps bit7 on miso for the next rise.
          shout_q <= {shout_q[6:0], 1'b0};
        end
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_bus
    assign bus.reg_bus[8*g +: 8] = regs_q[g];
  end

  assign bus.miso      = shout_q[7];
  assign bus.miso_oe   = oe_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register address width (register file depth 2**ADDR_W).
REQ-002 SHALL have parameter RST_VAL, default 8'h00, reset value of every register.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic sits on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cs_n  input  1  SPI chip select from the master, active-low, asynchronous to clk.
REQ-006 SHALL have port sclk  input  1  SPI clock from the master, mode 0, asynchronous to clk.
REQ-007 SHALL have port mosi  input  1  SPI data from the master.
REQ-008 SHALL have port miso  output  1  SPI data to the master.
REQ-009 SHALL have port miso_oe  output  1  miso drive enable; high only while cs_n is low (synchronised).
REQ-010 SHALL have port reg_bus  output  8*2**ADDR_W  all registers; register i is at reg_bus[8*i+:8].
REQ-011 SHALL have port wr_valid  output  1  one-clk pulse per register write.
REQ-012 SHALL have port wr_addr  output  ADDR_W  address of the register being written, valid with wr_valid.
REQ-013 SHALL have port wr_data  output  8  data being written, valid with wr_valid.
REQ-014 SHALL have port frame_err  output  1  sticky flag: cs_n rose mid-byte; cleared by reset or by the next cs_n fall.

Function
REQ-015 SHALL pass cs_n, sclk and mosi through 2-FF synchronisers, then detect sclk edges from the synchronised value; the master's sclk SHALL be at most clk/4.
REQ-016 SHALL sample mosi on each detected sclk rise, MSB first; 3-bit bit counter, byte complete on the 8th rise.
REQ-017 SHALL run FSM states IDLE, CMD, DATA: IDLE->CMD on synchronised cs_n fall; CMD->DATA on command byte complete; DATA->DATA on every subsequent byte; any state->IDLE on synchronised cs_n rise.
REQ-018 Command byte: bit7 = 1 read / 0 write, bits[ADDR_W-1:0] = start address, remaining bits ignored.
REQ-019 Write: on each complete DATA byte, SHALL update the register and pulse wr_valid with wr_addr/wr_data exactly 1 clk after the 8th-rise detection.
REQ-020 Read: on command completion, SHALL load the addressed register into the shift-out register and present bit7 on miso before the next sclk rise; further bits SHALL change on detected sclk falls.
REQ-021 Read bursts SHALL reload the shift-out register at each byte boundary with the next address's register.
REQ-022 Bytes received during a read transaction SHALL be discarded; no wr_valid is issued.
REQ-023 cs_n rise with bit counter != 0 SHALL set frame_err, drop the partial byte, and leave registers unchanged; cs_n rise with counter == 0 SHALL NOT set it.
REQ-024 In IDLE, miso SHALL be 0 and miso_oe SHALL be 0.
REQ-025 A write to an address in the same clk as it is being loaded for reading SHALL NOT occur (single master); no arbitration required.

Reset
REQ-026 While rst is high, all registers SHALL equal RST_VAL, FSM=IDLE, bit counter=0, miso=0, miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0, and synchronisers SHALL hold the idle levels (cs_n=1, sclk=0).
REQ-027 Reset asserted mid-transaction SHALL abort it; after release, the block SHALL wait for a fresh cs_n fall before accepting a command byte.

Configuration
REQ-028 With macro SPI_SLAVE_AUTOINC_EN defined, the address SHALL increment after each data byte, wrapping from 2**ADDR_W-1 to 0, for both reads and writes.
REQ-029 Without SPI_SLAVE_AUTOINC_EN, the address SHALL stay fixed for the whole transaction, so repeated bytes re-read or re-write the same register.

Verification
REQ-030 Write 8'h03, 8'hA5 -> one wr_valid pulse, wr_addr=3, wr_data=8'hA5; reg_bus[31:24]=8'hA5.
REQ-031 After REQ-030, send 8'h83, 8'h00 -> master captures 8'hA5 on miso; no wr_valid; miso_oe low after cs_n rise.
REQ-032 With SPI_SLAVE_AUTOINC_EN defined, write 8'h0F, 8'h11, 8'h22 -> reg 15=8'h11, reg 0=8'h22 (wrap); two wr_valid pulses.
REQ-033 Without SPI_SLAVE_AUTOINC_EN, write 8'h02, 8'h11, 8'h22 -> reg 2=8'h22, reg 3 unchanged; two wr_valid pulses, both with wr_addr=2.
REQ-034 Write 8'h05, then 5 bits of 8'hFF, then cs_n rise -> frame_err=1, reg 5 unchanged; next cs_n fall clears frame_err.
REQ-035 Assert rst after the 4th data bit of a write -> every register reads RST_VAL; an 8'h85, 8'h00 read then returns 8'h00.
